// File: rtl/fft_pkg.sv
// Shared FFT datapath constants and the complex bin format.
// Used by both the FFT input stage and the output handler.
package fft_pkg;

  localparam int FFT_WIDTH = 16;
  localparam int FFT_SIZE  = 1024;
  localparam int IDX_WIDTH = $clog2(FFT_SIZE);
  localparam int MAG_WIDTH = FFT_WIDTH + 1;

  // Wire order matches tdata: {imag, real}.
  typedef struct packed {
    logic signed [FFT_WIDTH-1:0] im;
    logic signed [FFT_WIDTH-1:0] re;
  } fft_bin_t;

endpackage

// File: rtl/fft_output_handler_if.sv
// Stream bundle of the FFT output handler: AXIS bins in, magnitudes,
// peak report and frame error out. slave = handler, master = env.
interface fft_output_handler_if #(
  parameter int FFT_WIDTH = fft_pkg::FFT_WIDTH,
  parameter int FFT_SIZE  = fft_pkg::FFT_SIZE
);

  localparam int IDX_WIDTH = $clog2(FFT_SIZE);
  localparam int MAG_WIDTH = FFT_WIDTH + 1;

  logic [2*FFT_WIDTH-1:0] s_axis_tdata;
  logic                   s_axis_tvalid;
  logic                   s_axis_tlast;
  logic                   s_axis_tready;

  logic [MAG_WIDTH-1:0]   mag_data;
  logic [IDX_WIDTH-1:0]   mag_idx;
  logic                   mag_valid;
  logic                   mag_last;
  logic                   mag_ready;

  logic [IDX_WIDTH-1:0]   peak_idx;
  logic [MAG_WIDTH-1:0]   peak_mag;
  logic                   peak_valid;
  logic                   frame_err;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, mag_ready,
    output s_axis_tready, mag_data, mag_idx, mag_valid, mag_last,
    output peak_idx, peak_mag, peak_valid, frame_err
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, mag_ready,
    input  s_axis_tready, mag_data, mag_idx, mag_valid, mag_last,
    input  peak_idx, peak_mag, peak_valid, frame_err
  );

endinterface

// File: rtl/fft_mag_approx.sv
// Two-stage magnitude: S1 saturating |re|,|im|; S2 max + min/4 + min/8.
// Ports: en advances both stages; in_* bin+tag in; out_* mag+tag out.
module fft_mag_approx #(
  parameter int W  = 16,
  parameter int IW = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                in_vld,
  input  logic                in_last,
  input  logic [IW-1:0]       in_idx,
  input  logic signed [W-1:0] in_re,
  input  logic signed [W-1:0] in_im,
  output logic                out_vld,
  output logic                out_last,
  output logic [IW-1:0]       out_idx,
  output logic [W:0]          out_mag
);

  localparam int MW = W + 1;

  // The most negative input has no positive twin; clamp it.
  function automatic logic [W-2:0] sat_abs(
    input logic signed [W-1:0] x
  );
    logic [W-1:0] n;
    n = ~x + 1'b1;
    if (!x[W-1])        return x[W-2:0];
    if (x[W-2:0] == '0) return '1;
    return n[W-2:0];
  endfunction

  logic          v1_q, v1_d;
  logic          l1_q, l1_d;
  logic [IW-1:0] i1_q, i1_d;
  logic [W-2:0]  ar_q, ar_d;
  logic [W-2:0]  ai_q, ai_d;

  logic          v2_q, v2_d;
  logic          l2_q, l2_d;
  logic [IW-1:0] i2_q, i2_d;
  logic [MW-1:0] m2_q, m2_d;

  logic [W-2:0]  mx, mn;

  always_comb begin
    v1_d = v1_q;
    l1_d = l1_q;
    i1_d = i1_q;
    ar_d = ar_q;
    ai_d = ai_q;
    v2_d = v2_q;
    l2_d = l2_q;
    i2_d = i2_q;
    m2_d = m2_q;
    mx   = (ar_q >= ai_q) ? ar_q : ai_q;
    mn   = (ar_q >= ai_q) ? ai_q : ar_q;
    if (en) begin
      v1_d = in_vld;
      v2_d = v1_q;
      if (in_vld) begin
        l1_d = in_last;
        i1_d = in_idx;
        ar_d = sat_abs(in_re);
        ai_d = sat_abs(in_im);
      end
      if (v1_q) begin
        l2_d = l1_q;
        i2_d = i1_q;
        m2_d = MW'(mx) + MW'(mn >> 2)
             + MW'(mn >> 3);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      l1_q <= 1'b0;
      i1_q <= '0;
      ar_q <= '0;
      ai_q <= '0;
      v2_q <= 1'b0;
      l2_q <= 1'b0;
      i2_q <= '0;
      m2_q <= '0;
    end else begin
      v1_q <= v1_d;
      l1_q <= l1_d;
      i1_q <= i1_d;
      ar_q <= ar_d;
      ai_q <= ai_d;
      v2_q <= v2_d;
      l2_q <= l2_d;
      i2_q <= i2_d;
      m2_q <= m2_d;
    end
  end

  assign out_vld  = v2_q;
  assign out_last = v2_q & l2_q;
  assign out_idx  = i2_q;
  assign out_mag  = m2_q;

endmodule

// File: rtl/fft_output_handler.sv
// FFT output handler: tags bins, emits magnitudes, tracks frame peak.
// Ports: clk, rst_n (async low), bus = slave side of the stream bundle.
module fft_output_handler #(
  parameter int FFT_WIDTH     = fft_pkg::FFT_WIDTH,
  parameter int FFT_SIZE      = fft_pkg::FFT_SIZE,
  parameter int HALF_SPECTRUM = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fft_output_handler_if.slave  bus
);

  localparam int IDX_WIDTH = $clog2(FFT_SIZE);
  localparam int MAG_WIDTH = FFT_WIDTH + 1;
  localparam int EMIT_BINS =
    (HALF_SPECTRUM != 0) ? FFT_SIZE / 2 : FFT_SIZE;
  localparam logic [IDX_WIDTH-1:0] CTR_MAX =
    IDX_WIDTH'(FFT_SIZE - 1);
  localparam logic [IDX_WIDTH-1:0] LAST_EMIT =
    IDX_WIDTH'(EMIT_BINS - 1);

  fft_pkg::fft_bin_t beat;

  logic                 en, acc, keep, at_max, is_last;
  logic [IDX_WIDTH-1:0] ctr_q, ctr_d;
  logic                 err_q, err_d;

  logic                 mv, ml, hs, take;
  logic [IDX_WIDTH-1:0] midx;
  logic [MAG_WIDTH-1:0] mag;

  logic                 first_q, first_d;
  logic [IDX_WIDTH-1:0] trk_idx_q, trk_idx_d;
  logic [MAG_WIDTH-1:0] trk_mag_q, trk_mag_d;
  logic [IDX_WIDTH-1:0] nx_idx;
  logic [MAG_WIDTH-1:0] nx_mag;
  logic [IDX_WIDTH-1:0] pk_idx_q, pk_idx_d;
  logic [MAG_WIDTH-1:0] pk_mag_q, pk_mag_d;
  logic                 pv_q, pv_d;

  assign beat    = bus.s_axis_tdata;
  assign en      = !mv || bus.mag_ready;
  assign acc     = bus.s_axis_tvalid && en;
  assign at_max  = (ctr_q == CTR_MAX);
  assign keep    = (int'(ctr_q) < EMIT_BINS);
  // Early tlast also closes the emitted part of the frame.
  assign is_last = (ctr_q == LAST_EMIT) || bus.s_axis_tlast;

  always_comb begin
    ctr_d = ctr_q;
    err_d = err_q;
    if (acc) begin
      if (bus.s_axis_tlast || at_max) ctr_d = '0;
      else                            ctr_d = ctr_q + 1'b1;
      if (bus.s_axis_tlast != at_max) err_d = 1'b1;
    end
  end

  fft_mag_approx #(
    .W  (FFT_WIDTH),
    .IW (IDX_WIDTH)
  ) u_mag (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .in_vld  (acc && keep),
    .in_last (is_last),
    .in_idx  (ctr_q),
    .in_re   (beat.re),
    .in_im   (beat.im),
    .out_vld (mv),
    .out_last(ml),
    .out_idx (midx),
    .out_mag (mag)
  );

  // Strict > keeps the lowest index on ties.
  assign hs     = mv && bus.mag_ready;
  assign take   = first_q || (mag > trk_mag_q);
  assign nx_idx = take ? midx : trk_idx_q;
  assign nx_mag = take ? mag  : trk_mag_q;

  always_comb begin
    first_d   = first_q;
    trk_idx_d = trk_idx_q;
    trk_mag_d = trk_mag_q;
    pk_idx_d  = pk_idx_q;
    pk_mag_d  = pk_mag_q;
    pv_d      = 1'b0;
    if (hs) begin
      first_d   = ml;
      trk_idx_d = nx_idx;
      trk_mag_d = nx_mag;
      if (ml) begin
        pk_idx_d = nx_idx;
        pk_mag_d = nx_mag;
        pv_d     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctr_q     <= '0;
      err_q     <= 1'b0;
      first_q   <= 1'b1;
      trk_idx_q <= '0;
      trk_mag_q <= '0;
      pk_idx_q  <= '0;
      pk_mag_q  <= '0;
      pv_q      <= 1'b0;
    end else begin
      ctr_q     <= ctr_d;
      err_q     <= err_d;
      first_q   <= first_d;
      trk_idx_q <= trk_idx_d;
      trk_mag_q <= trk_mag_d;
      pk_idx_q  <= pk_idx_d;
      pk_mag_q  <= pk_mag_d;
      pv_q      <= pv_d;
    end
  end

  assign bus.s_axis_tready = en;
  assign bus.mag_data      = mag;
  assign bus.mag_idx       = midx;
  assign bus.mag_valid     = mv;
  assign bus.mag_last      = ml;
  assign bus.peak_idx      = pk_idx_q;
  assign bus.peak_mag      = pk_mag_q;
  assign bus.peak_valid    = pv_q;
  assign bus.frame_err     = err_q;

endmodule

// File: tb/tb_fft_output_handler.sv
// Self-checking bench for fft_output_handler (16 bins, half spectrum).
// Scoreboard model plus constant vector table and directed sequences.
module tb_fft_output_handler;

  localparam int W    = 16;
  localparam int N    = 16;
  localparam int HALF = N / 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fft_output_handler_if #(.FFT_WIDTH(W), .FFT_SIZE(N)) bus ();

  fft_output_handler #(
    .FFT_WIDTH    (W),
    .FFT_SIZE     (N),
    .HALF_SPECTRUM(1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct { int idx; int mag; bit last; } exp_t;
  typedef struct { int idx; int mag; } pk_t;
  typedef struct { logic [15:0] re; logic [15:0] im; int exp; } vec_t;

  exp_t eq[$];
  pk_t  pq[$];
  pk_t  fl[$];
  vec_t tbl[8];
  logic [31:0] fr[N];

  int n_cmp = 0;
  int n_bad = 0;
  int m_ctr = 0;
  bit m_err = 0;
  bit stall = 0;
  bit prev_pv = 0;
  int hold_mag, hold_idx;
  int n_out = 0, n_pk = 0;
  int pk_idx_obs = -1, pk_mag_obs = -1, last_idx_obs = -1;
  int obs_mag[N];

  function automatic void chk(string name, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endfunction

  function automatic int ref_mag(int re, int im);
    int ar, ai, mx, mn;
    ar = (re == -32768) ? 32767 : ((re < 0) ? -re : re);
    ai = (im == -32768) ? 32767 : ((im < 0) ? -im : im);
    mx = (ar > ai) ? ar : ai;
    mn = (ar > ai) ? ai : ar;
    return mx + mn / 4 + mn / 8;
  endfunction

  task automatic model_accept(input logic [31:0] d, input bit l);
    int idx, mag;
    bit lst;
    pk_t best;
    idx = m_ctr;
    mag = ref_mag(int'($signed(d[15:0])), int'($signed(d[31:16])));
    if (l != (idx == N - 1)) m_err = 1;
    m_ctr = (l || idx == N - 1) ? 0 : idx + 1;
    if (idx < HALF) begin
      lst = l || (idx == HALF - 1);
      eq.push_back('{idx, mag, lst});
      fl.push_back('{idx, mag});
      if (lst) begin
        best = fl[0];
        foreach (fl[i]) if (fl[i].mag > best.mag) best = fl[i];
        pq.push_back(best);
        fl.delete();
      end
    end
  endtask

  task automatic cyc(input bit v, input bit l, input logic [31:0] d,
                     input bit mr, output bit acc);
    exp_t e;
    pk_t p;
    @(negedge clk);
    bus.s_axis_tvalid = v;
    bus.s_axis_tlast  = l;
    bus.s_axis_tdata  = d;
    bus.mag_ready     = mr;
    #1;
    if (stall) begin
      chk("stall_valid", bus.mag_valid, 1);
      chk("stall_data", bus.mag_data, hold_mag);
      chk("stall_idx", bus.mag_idx, hold_idx);
    end
    chk("tready", bus.s_axis_tready, !(bus.mag_valid && !mr));
    chk("frame_err", bus.frame_err, m_err);
    if (bus.peak_valid) begin
      chk("peak_pulse_width", prev_pv, 0);
      if (pq.size() == 0) chk("peak_spurious", bus.peak_valid, 0);
      else begin
        p = pq.pop_front();
        chk("peak_idx", bus.peak_idx, p.idx);
        chk("peak_mag", bus.peak_mag, p.mag);
      end
      n_pk++;
      pk_idx_obs = bus.peak_idx;
      pk_mag_obs = bus.peak_mag;
    end
    prev_pv = bus.peak_valid;
    if (bus.mag_valid && mr) begin
      n_out++;
      if (eq.size() == 0) chk("mag_spurious", bus.mag_valid, 0);
      else begin
        e = eq.pop_front();
        chk("mag_idx", bus.mag_idx, e.idx);
        chk("mag_data", bus.mag_data, e.mag);
        chk("mag_last", bus.mag_last, e.last);
      end
      obs_mag[bus.mag_idx] = bus.mag_data;
      if (bus.mag_last) last_idx_obs = bus.mag_idx;
    end
    stall    = bus.mag_valid && !mr;
    hold_mag = bus.mag_data;
    hold_idx = bus.mag_idx;
    acc      = v && bus.s_axis_tready;
    if (acc) model_accept(d, l);
  endtask

  task automatic send_beat(input logic [31:0] d, input bit l,
                           input int rmode);
    bit acc;
    bit mr;
    acc = 0;
    for (int t = 0; t < 100 && !acc; t++) begin
      mr = (rmode == 1) ? bit'($urandom_range(0, 1)) : 1'b1;
      cyc(1'b1, l, d, mr, acc);
    end
    chk("accept_timeout", acc, 1);
  endtask

  task automatic send_frame(input int nb, input int last_at,
                            input int rmode);
    for (int i = 0; i < nb; i++) send_beat(fr[i], i == last_at, rmode);
  endtask

  task automatic drain();
    bit acc;
    for (int t = 0; t < 60 && (eq.size() > 0 || pq.size() > 0); t++)
      cyc(1'b0, 1'b0, 32'd0, 1'b1, acc);
    repeat (3) cyc(1'b0, 1'b0, 32'd0, 1'b1, acc);
    chk("drain_mag", eq.size(), 0);
    chk("drain_peak", pq.size(), 0);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_mag_valid", bus.mag_valid, 0);
    chk("rst_mag_data", bus.mag_data, 0);
    chk("rst_mag_idx", bus.mag_idx, 0);
    chk("rst_mag_last", bus.mag_last, 0);
    chk("rst_peak_valid", bus.peak_valid, 0);
    chk("rst_peak_idx", bus.peak_idx, 0);
    chk("rst_peak_mag", bus.peak_mag, 0);
    chk("rst_frame_err", bus.frame_err, 0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
    #1;
    chk_reset_outputs();
    eq.delete();
    pq.delete();
    fl.delete();
    m_ctr   = 0;
    m_err   = 0;
    stall   = 0;
    prev_pv = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic clear_frame();
    for (int i = 0; i < N; i++) fr[i] = 32'd0;
  endtask

  task automatic rand_frame();
    for (int i = 0; i < N; i++) fr[i] = $urandom();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit acc;
    int o0, p0;
    tbl[0] = '{16'd1000, 16'd0, 1000};
    tbl[1] = '{16'd300, 16'd400, 512};
    tbl[2] = '{16'(-32768), 16'(-32768), 45053};
    tbl[3] = '{16'd0, 16'(-700), 700};
    tbl[4] = '{16'(-1), 16'd1, 1};
    tbl[5] = '{16'd32767, 16'(-32768), 45053};
    tbl[6] = '{16'(-100), 16'(-100), 137};
    tbl[7] = '{16'd5, 16'(-8), 9};

    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
    bus.s_axis_tdata  = '0;
    bus.mag_ready     = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Single tone at bin 5.
    clear_frame();
    fr[5] = {16'd0, 16'd1000};
    o0 = n_out;
    p0 = n_pk;
    send_frame(N, N - 1, 0);
    drain();
    chk("t1_outputs", n_out - o0, HALF);
    chk("t1_peaks", n_pk - p0, 1);
    chk("t1_peak_idx", pk_idx_obs, 5);
    chk("t1_peak_mag", pk_mag_obs, 1000);
    chk("t1_mag5", obs_mag[5], 1000);
    chk("t1_last_idx", last_idx_obs, HALF - 1);

    // Magnitude vector table in bins 0..7.
    clear_frame();
    for (int i = 0; i < 8; i++) fr[i] = {tbl[i].im, tbl[i].re};
    send_frame(N, N - 1, 0);
    drain();
    for (int i = 0; i < 8; i++) chk("tbl_mag", obs_mag[i], tbl[i].exp);
    chk("tbl_peak_idx", pk_idx_obs, 2);
    chk("tbl_peak_mag", pk_mag_obs, 45053);

    // Equal magnitudes: lowest index wins.
    clear_frame();
    fr[2] = {16'd0, 16'd700};
    fr[6] = {16'(-700), 16'd0};
    send_frame(N, N - 1, 0);
    drain();
    chk("tie_peak_idx", pk_idx_obs, 2);
    chk("tie_peak_mag", pk_mag_obs, 700);

    // Random data under random backpressure.
    for (int f = 0; f < 4; f++) begin
      rand_frame();
      send_frame(N, N - 1, 1);
    end
    drain();

    // tlast on beat 9, then a normal frame.
    rand_frame();
    send_frame(9, 8, 0);
    rand_frame();
    send_frame(N, N - 1, 1);
    drain();
    chk("err_sticky", bus.frame_err, 1);

    // tlast inside the emitted half closes the frame early.
    rand_frame();
    send_frame(4, 3, 0);
    drain();
    chk("early_last_idx", last_idx_obs, 3);
    rand_frame();
    send_frame(N, N - 1, 0);
    drain();

    // Reset mid-frame under backpressure.
    rand_frame();
    for (int i = 0; i < 4; i++) send_beat(fr[i], 1'b0, 1);
    cyc(1'b1, 1'b0, fr[4], 1'b0, acc);
    cyc(1'b1, 1'b0, fr[4], 1'b0, acc);
    apply_reset();
    o0 = n_out;
    p0 = n_pk;
    rand_frame();
    send_frame(N, N - 1, 1);
    drain();
    chk("rst_frame_outputs", n_out - o0, HALF);
    chk("rst_frame_peaks", n_pk - p0, 1);

    // Counter wrap with no tlast.
    rand_frame();
    send_frame(N, -1, 0);
    drain();
    chk("wrap_err", bus.frame_err, 1);
    rand_frame();
    send_frame(N, N - 1, 1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
